branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Decode-stage controller that sequences the branch comparator: detects RAW hazards on branch source registers against the E/M/W producers, and holds D until operands are forwardable.
- Drives the comparator's forwarding selects and qualifies its Equal_D result into taken/PC-select.
- Keeps saturating branch performance counters.
- Sits between the hazard unit, the D-stage forwarding muxes and the Compare block.

Parameters:
- TNEW_W, 2, width of producer Tnew fields (max Tnew = 2^TNEW_W-1)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- branch_D  in  1  valid branch instruction in D
- CMP_D  in  3  compare code (001 eq, 010 gez, 011 gtz, 100 lez, 101 ltz, 110 ne)
- rs_D  in  5  source register 1
- rt_D  in  5  source register 2
- flush_D  in  1  abort D instruction (exception/redirect)
- regwrite_E, waddr_E[4:0], tnew_E[TNEW_W-1:0]  in  E-stage producer
- regwrite_M, waddr_M[4:0], tnew_M[TNEW_W-1:0]  in  M-stage producer
- regwrite_W, waddr_W[4:0]  in  W-stage producer (Tnew always 0)
- Equal_D  in  1  comparator result
- stall_D  out  1  freeze F/D, bubble E
- fwd_rs_D  out  2  rs source: 0 regfile, 1 M result, 2 W result
- fwd_rt_D  out  2  rt source, same encoding
- taken_D  out  1  branch resolved taken this cycle
- pc_sel_D  out  1  select branch target (equal to taken_D)
- br_cnt, taken_cnt, stall_cnt  out  CNT_W  performance counters

Behaviour:
- Reset: state IDLE, cnt=0, all counters 0. Outputs stall_D=0, taken_D=0, pc_sel_D=0, fwd=0.
- rt_D is used only for CMP_D 001/110. CMP_D 000/111 count as non-branch: never stall, never taken, not counted.
- Match rule: a producer matches a used source when regwrite=1, waddr==src and src!=0.
- need = max of tnew_E over E matches and tnew_M over M matches; 0 if no match.
- States:
  - IDLE:
    - branch_D & ~flush_D & need==0: resolve this cycle; state stays IDLE.
    - branch_D & ~flush_D & need>0: stall_D=1, cnt<=need-1, go WAIT.
  - WAIT:
    - cnt!=0: stall_D=1, cnt<=cnt-1.
    - cnt==0: stall_D=0, resolve, go IDLE.
  - Required stall cycles = need, exactly.
- Resolve cycle:
  - taken_D = pc_sel_D = Equal_D. Combinational within the cycle; no added latency.
  - br_cnt += 1; taken_cnt += Equal_D.
- Forwarding selects are combinational in every state. Priority per source: M match with tnew_M==0 -> 1; else W match -> 2; else 0. Zero register -> 0.
- stall_cnt += 1 on every cycle with stall_D=1.
- All counters saturate at all-ones; no wrap.
- Stall_D is never asserted for a producer with Tnew 0 in M, or for any producer in W.
- flush_D, any state: state<=IDLE, cnt<=0, stall_D=0, taken_D=0, no counter update that cycle.
- reset has priority over flush_D. reset mid-WAIT returns to IDLE next edge with counters cleared.
- branch_D dropping in WAIT without flush: return to IDLE, no resolve, no count.

Test Plan:
- Reset, then beq $1,$1 (CMP_D=001) with no producers and Equal_D=1 -> same-cycle taken_D=1, stall_D=0, fwd 0/0; br_cnt=1, taken_cnt=1.
- bgtz $5 (CMP_D=011) with E producer waddr_E=5, tnew_E=2 -> stall_D high exactly 2 cycles; resolve on 3rd cycle; stall_cnt=2.
- bne $3,$4 (CMP_D=110), M producer waddr_M=4 tnew_M=0 and W producer waddr_W=4 -> fwd_rt_D=1 (M priority), fwd_rs_D=0, no stall.
- Branch on $0 with E producer waddr_E=0, tnew_E=2 -> no stall, fwd=0.
- Stall in progress (need=2), flush_D in cycle 2 -> IDLE next cycle, no taken, br_cnt unchanged; repeat with reset -> all counters 0.
- Force taken_cnt to all-ones, taken branch -> stays all-ones. CMP_D=111 with matching producer -> no stall, no count.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Decode-stage branch resolution bundle: branch operands, E/M/W producer
// scoreboard, comparator result in; stall, forwarding selects, outcome and counters out.
interface branch_resolve_ctrl_if #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
);
  logic              branch_D;
  logic [2:0]        CMP_D;
  logic [4:0]        rs_D;
  logic [4:0]        rt_D;
  logic              flush_D;
  logic              regwrite_E;
  logic [4:0]        waddr_E;
  logic [TNEW_W-1:0] tnew_E;
  logic              regwrite_M;
  logic [4:0]        waddr_M;
  logic [TNEW_W-1:0] tnew_M;
  logic              regwrite_W;
  logic [4:0]        waddr_W;
  logic              Equal_D;
  logic              stall_D;
  logic [1:0]        fwd_rs_D;
  logic [1:0]        fwd_rt_D;
  logic              taken_D;
  logic              pc_sel_D;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output branch_D, CMP_D, rs_D, rt_D, flush_D,
           regwrite_E, waddr_E, tnew_E, regwrite_M, waddr_M, tnew_M,
           regwrite_W, waddr_W, Equal_D,
    input  stall_D, fwd_rs_D, fwd_rt_D, taken_D, pc_sel_D,
           br_cnt, taken_cnt, stall_cnt
  );

  modport slave (
    input  branch_D, CMP_D, rs_D, rt_D, flush_D,
           regwrite_E, waddr_E, tnew_E, regwrite_M, waddr_M, tnew_M,
           regwrite_W, waddr_W, Equal_D,
    output stall_D, fwd_rs_D, fwd_rt_D, taken_D, pc_sel_D,
           br_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch controller: RAW hazard stall sequencing against E/M/W producers,
// comparator forwarding selects, taken/PC-select qualification and perf counters.

// One branch source operand: hazard depth and forwarding select.
module branch_src_hazard #(
  parameter int TNEW_W = 2
) (
  input  logic              used,
  input  logic [4:0]        src,
  input  logic              regwrite_E,
  input  logic [4:0]        waddr_E,
  input  logic [TNEW_W-1:0] tnew_E,
  input  logic              regwrite_M,
  input  logic [4:0]        waddr_M,
  input  logic [TNEW_W-1:0] tnew_M,
  input  logic              regwrite_W,
  input  logic [4:0]        waddr_W,
  output logic [TNEW_W-1:0] need,
  output logic [1:0]        fwd
);
  logic              live, hit_e, hit_m, hit_w;
  logic [TNEW_W-1:0] need_e, need_m;

  always_comb begin
    live   = used && (src != 5'd0);
    hit_e  = live && regwrite_E && (waddr_E == src);
    hit_m  = live && regwrite_M && (waddr_M == src);
    hit_w  = live && regwrite_W && (waddr_W == src);
    need_e = hit_e ? tnew_E : '0;
    need_m = hit_m ? tnew_M : '0;
    need   = (need_e > need_m) ? need_e : need_m;
    // M only forwards once its value exists; W is always ready.
    if (hit_m && (tnew_M == '0)) fwd = 2'd1;
    else if (hit_w)              fwd = 2'd2;
    else                         fwd = 2'd0;
  end
endmodule

module branch_resolve_ctrl #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus
);
  localparam int NUM_SRC = 2;

  typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

  state_t            state_q, state_n;
  logic [TNEW_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q, stall_cnt_q;

  logic                             cmp_valid, two_src, is_br;
  logic [NUM_SRC-1:0]               src_used;
  logic [NUM_SRC-1:0][4:0]          src;
  logic [NUM_SRC-1:0][TNEW_W-1:0]   src_need;
  logic [NUM_SRC-1:0][1:0]          src_fwd;
  logic [TNEW_W-1:0]                need;
  logic                             stall, resolve, taken;

  // Codes 000/111 are not branches; only eq/ne read rt.
  always_comb begin
    cmp_valid   = (bus.CMP_D != 3'b000) && (bus.CMP_D != 3'b111);
    two_src     = (bus.CMP_D == 3'b001) || (bus.CMP_D == 3'b110);
    is_br       = bus.branch_D && cmp_valid;
    src[0]      = bus.rs_D;
    src[1]      = bus.rt_D;
    src_used[0] = cmp_valid;
    src_used[1] = two_src;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    branch_src_hazard #(.TNEW_W(TNEW_W)) u_src (
      .used       (src_used[g]),
      .src        (src[g]),
      .regwrite_E (bus.regwrite_E),
      .waddr_E    (bus.waddr_E),
      .tnew_E     (bus.tnew_E),
      .regwrite_M (bus.regwrite_M),
      .waddr_M    (bus.waddr_M),
      .tnew_M     (bus.tnew_M),
      .regwrite_W (bus.regwrite_W),
      .waddr_W    (bus.waddr_W),
      .need       (src_need[g]),
      .fwd        (src_fwd[g])
    );
  end

  always_comb begin
    need = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_need[i] > need) need = src_need[i];
  end

  // Next state / outputs; flush wins over everything in the datapath.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    stall   = 1'b0;
    resolve = 1'b0;
    if (bus.flush_D) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_br) begin
            if (need == '0) begin
              resolve = 1'b1;
            end else begin
              stall   = 1'b1;
              cnt_n   = need - 1'b1;
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (!is_br) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_n = cnt_q - 1'b1;
          end else begin
            resolve = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    taken = resolve && bus.Equal_D;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      br_cnt_q    <= sat_inc(br_cnt_q, resolve);
      taken_cnt_q <= sat_inc(taken_cnt_q, taken);
      stall_cnt_q <= sat_inc(stall_cnt_q, stall);
    end
  end

  assign bus.stall_D   = stall;
  assign bus.taken_D   = taken;
  assign bus.pc_sel_D  = taken;
  assign bus.fwd_rs_D  = src_fwd[0];
  assign bus.fwd_rt_D  = src_fwd[1];
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl; narrow counters so saturation is reachable.
module tb_branch_resolve_ctrl;
  localparam int TW   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    int         stalls;
    logic       tk;
    logic [1:0] frs;
    logic [1:0] frt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [CW-1:0] exp_br, exp_tk, exp_st;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.TNEW_W(TW), .CNT_W(CW)) bus ();

  branch_resolve_ctrl #(.TNEW_W(TW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v, input int a);
    int s;
    s = int'(v) + a;
    return (s > MAXC) ? CW'(MAXC) : CW'(s);
  endfunction

  task automatic clr_prod();
    bus.regwrite_E = 0; bus.waddr_E = 0; bus.tnew_E = 0;
    bus.regwrite_M = 0; bus.waddr_M = 0; bus.tnew_M = 0;
    bus.regwrite_W = 0; bus.waddr_W = 0;
  endtask

  task automatic push_exp(input int st, input logic tk, input logic [1:0] frs, input logic [1:0] frt);
    exp_t e;
    e.stalls = st; e.tk = tk; e.frs = frs; e.frt = frt;
    q.push_back(e);
  endtask

  // Drives one branch and observes the resolve cycle; stalls=-1 means it never resolved.
  task automatic step_branch(input logic [2:0] cmp, input logic [4:0] rs, input logic [4:0] rt,
                             input logic eq, output int stalls, output logic [5:0] obs);
    bit done = 0;
    bus.branch_D = 1; bus.CMP_D = cmp; bus.rs_D = rs; bus.rt_D = rt; bus.Equal_D = eq;
    stalls = 0; obs = '0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (bus.stall_D) stalls++;
      else begin
        obs = {bus.taken_D, bus.pc_sel_D, bus.fwd_rs_D, bus.fwd_rt_D};
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) stalls = -1;
    bus.branch_D = 0; bus.CMP_D = 0; bus.rs_D = 0; bus.rt_D = 0; bus.Equal_D = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_br = 0; exp_tk = 0; exp_st = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus.stall_D, bus.taken_D, bus.pc_sel_D, bus.fwd_rs_D, bus.fwd_rt_D} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000000",
        {bus.stall_D, bus.taken_D, bus.pc_sel_D, bus.fwd_rs_D, bus.fwd_rt_D});
    end
    checks++;
    if ({bus.br_cnt, bus.taken_cnt, bus.stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
        bus.br_cnt, bus.taken_cnt, bus.stall_cnt);
    end
    @(posedge clk); #1;
  endtask

  // Runs one branch against the scoreboard head and updates the counter model.
  task automatic run_and_score(input string name, input logic [2:0] cmp, input logic [4:0] rs,
                               input logic [4:0] rt, input logic eq);
    int st; logic [5:0] obs; exp_t e;
    step_branch(cmp, rs, rt, eq, st, obs);
    e = q.pop_front();
    checks++;
    if (st !== e.stalls) begin
      errors++; $display("FAIL %s_stalls: got %0d want %0d", name, st, e.stalls);
    end
    checks++;
    if (obs !== {e.tk, e.tk, e.frs, e.frt}) begin
      errors++; $display("FAIL %s_outcome: got %b want %b", name, obs, {e.tk, e.tk, e.frs, e.frt});
    end
    exp_br = sat(exp_br, 1);
    exp_tk = sat(exp_tk, int'(e.tk));
    exp_st = sat(exp_st, e.stalls);
  endtask

  task automatic check_counters(input string name);
    @(negedge clk);
    checks++;
    if ({bus.br_cnt, bus.taken_cnt, bus.stall_cnt} !== {exp_br, exp_tk, exp_st}) begin
      errors++; $display("FAIL %s_counters: got %0d/%0d/%0d want %0d/%0d/%0d", name,
        bus.br_cnt, bus.taken_cnt, bus.stall_cnt, exp_br, exp_tk, exp_st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_hazard();
    push_exp(0, 1, 2'd0, 2'd0);
    run_and_score("beq_nohaz", 3'b001, 5'd1, 5'd1, 1'b1);
    check_counters("beq_nohaz");
  endtask

  task automatic test_e_stall();
    bus.regwrite_E = 1; bus.waddr_E = 5; bus.tnew_E = 2;
    push_exp(2, 1, 2'd0, 2'd0);
    run_and_score("bgtz_e2", 3'b011, 5'd5, 5'd0, 1'b1);
    clr_prod();
    check_counters("bgtz_e2");
    bus.regwrite_M = 1; bus.waddr_M = 7; bus.tnew_M = 1;
    push_exp(1, 0, 2'd0, 2'd0);
    run_and_score("blez_m1", 3'b100, 5'd7, 5'd0, 1'b0);
    clr_prod();
    check_counters("blez_m1");
  endtask

  task automatic test_fwd();
    bus.regwrite_M = 1; bus.waddr_M = 4; bus.tnew_M = 0;
    bus.regwrite_W = 1; bus.waddr_W = 4;
    push_exp(0, 0, 2'd0, 2'd1);
    run_and_score("bne_mprio", 3'b110, 5'd3, 5'd4, 1'b0);
    clr_prod();
    bus.regwrite_W = 1; bus.waddr_W = 6;
    push_exp(0, 1, 2'd2, 2'd0);
    run_and_score("beq_wfwd", 3'b001, 5'd6, 5'd9, 1'b1);
    clr_prod();
    // bgez ignores rt, so an E producer of rt must not stall.
    bus.regwrite_E = 1; bus.waddr_E = 8; bus.tnew_E = 2;
    push_exp(0, 0, 2'd0, 2'd0);
    run_and_score("bgez_rt_unused", 3'b010, 5'd2, 5'd8, 1'b0);
    clr_prod();
    check_counters("fwd");
  endtask

  task automatic test_zero_reg();
    bus.regwrite_E = 1; bus.waddr_E = 0; bus.tnew_E = 2;
    bus.regwrite_W = 1; bus.waddr_W = 0;
    push_exp(0, 1, 2'd0, 2'd0);
    run_and_score("bgtz_r0", 3'b011, 5'd0, 5'd0, 1'b1);
    clr_prod();
    check_counters("r0");
  endtask

  task automatic test_nonbranch();
    bus.regwrite_E = 1; bus.waddr_E = 5; bus.tnew_E = 2;
    bus.branch_D = 1; bus.CMP_D = 3'b111; bus.rs_D = 5; bus.rt_D = 5; bus.Equal_D = 1;
    @(negedge clk);
    checks++;
    if ({bus.stall_D, bus.taken_D} !== 2'b00) begin
      errors++; $display("FAIL cmp111: stall/taken got %b want 00", {bus.stall_D, bus.taken_D});
    end
    @(posedge clk); #1;
    bus.branch_D = 0; bus.CMP_D = 0; bus.Equal_D = 0;
    clr_prod();
    check_counters("cmp111");
  endtask

  task automatic test_drop();
    bus.regwrite_E = 1; bus.waddr_E = 5; bus.tnew_E = 2;
    bus.branch_D = 1; bus.CMP_D = 3'b011; bus.rs_D = 5; bus.Equal_D = 1;
    @(negedge clk);
    checks++;
    if (bus.stall_D !== 1'b1) begin
      errors++; $display("FAIL drop_stall1: got %b want 1", bus.stall_D);
    end
    @(posedge clk); #1;
    bus.branch_D = 0;
    @(negedge clk);
    checks++;
    if ({bus.stall_D, bus.taken_D} !== 2'b00) begin
      errors++; $display("FAIL drop_release: stall/taken got %b want 00", {bus.stall_D, bus.taken_D});
    end
    @(posedge clk); #1;
    bus.CMP_D = 0; bus.rs_D = 0; bus.Equal_D = 0;
    clr_prod();
    exp_st = sat(exp_st, 1);
    check_counters("drop");
  endtask

  task automatic test_flush();
    bus.regwrite_E = 1; bus.waddr_E = 5; bus.tnew_E = 2;
    bus.branch_D = 1; bus.CMP_D = 3'b011; bus.rs_D = 5; bus.Equal_D = 1;
    @(negedge clk);
    checks++;
    if (bus.stall_D !== 1'b1) begin
      errors++; $display("FAIL flush_stall1: got %b want 1", bus.stall_D);
    end
    @(posedge clk); #1;
    bus.flush_D = 1;
    @(negedge clk);
    checks++;
    if ({bus.stall_D, bus.taken_D, bus.pc_sel_D} !== 3'b000) begin
      errors++; $display("FAIL flush_cycle: got %b want 000", {bus.stall_D, bus.taken_D, bus.pc_sel_D});
    end
    @(posedge clk); #1;
    bus.flush_D = 0; bus.branch_D = 0; bus.CMP_D = 0; bus.rs_D = 0; bus.Equal_D = 0;
    clr_prod();
    exp_st = sat(exp_st, 1);
    check_counters("flush");
    // Same stall, now cut short by reset.
    bus.regwrite_E = 1; bus.waddr_E = 5; bus.tnew_E = 2;
    bus.branch_D = 1; bus.CMP_D = 3'b011; bus.rs_D = 5; bus.Equal_D = 1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    bus.branch_D = 0; bus.CMP_D = 0; bus.rs_D = 0; bus.Equal_D = 0;
    clr_prod();
    exp_br = 0; exp_tk = 0; exp_st = 0;
    @(negedge clk);
    checks++;
    if (bus.stall_D !== 1'b0) begin
      errors++; $display("FAIL reset_midwait_stall: got %b want 0", bus.stall_D);
    end
    @(posedge clk); #1;
    check_counters("reset_midwait");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 18; i++) push_exp(0, (i != 5), 2'd0, 2'd0);
    for (int i = 0; i < 18; i++) run_and_score("b2b", 3'b001, 5'd2, 5'd3, (i != 5));
    check_counters("saturate");
    checks++;
    if (bus.taken_cnt !== CW'(MAXC)) begin
      errors++; $display("FAIL taken_sat: got %0d want %0d", bus.taken_cnt, MAXC);
    end
    push_exp(0, 1, 2'd0, 2'd0);
    run_and_score("post_sat", 3'b001, 5'd1, 5'd1, 1'b1);
    check_counters("post_sat");
  endtask

  initial begin
    reset = 1;
    bus.branch_D = 0; bus.CMP_D = 0; bus.rs_D = 0; bus.rt_D = 0;
    bus.flush_D = 0; bus.Equal_D = 0;
    clr_prod();
    test_reset();
    test_no_hazard();
    test_e_stall();
    test_fwd();
    test_zero_reg();
    test_nonbranch();
    test_drop();
    test_flush();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
